differentiator_datapath_controller: RTL
=======================================

// Module: differentiator_datapath_controller
// PURPOSE
//   Receive-side inverse of the 4-sample integrator. It consumes the integrator's
//   partial-sum stream, where each frame holds 4 running sums and the next frame
//   restarts from the new sample. It recovers the original word_size-bit samples.
//   A datapath (difference engine) and a controller FSM (frame counter, hold/restart).
//   Sits downstream of the integrator output, e.g. loopback check or decoder stage.
// PARAMETERS
//   word_size  3  width of a recovered sample; input sum width is word_size+2
// PORTS
//   clock         in   1             single clock, all state updates on posedge
//   reset         in   1             synchronous, active-high; dominates all inputs
//   enable        in   1             1 = consume data_in this cycle; 0 = hold
//   data_in       in   word_size+2   partial sum from integrator (unsigned)
//   data_out      out  word_size     recovered sample (registered)
//   sample_valid  out  1             1-cycle pulse: data_out updated this cycle
//   frame_start   out  1             with sample_valid: sample is 1st of a frame
//   range_err     out  1             with sample_valid: difference out of range
// BEHAVIOUR
//   Reset: data_out=0, sample_valid=0, frame_start=0, range_err=0, prev_sum=0,
//     count=0, state=IDLE. Reset wins over a simultaneous enable.
//   FSM states: IDLE (post-reset), RUN, HOLD.
//     IDLE: enable=1 -> RUN, consume as frame sample 0.
//     RUN:  enable=1 -> stay, consume sample count; enable=0 -> HOLD.
//     HOLD: enable=1 -> RUN, count forced to 0 (a new frame starts, mirroring
//       the integrator restart); enable=0 -> stay.
//   Consume (enable=1, no reset), with 1-cycle latency from data_in to data_out:
//     if count==0: diff = data_in; frame_start<=1
//     else: diff = data_in - prev_sum, computed in word_size+2 bits with borrow.
//     data_out<=diff[word_size-1:0]; prev_sum<=data_in; count<=count+1 mod 4.
//     sample_valid<=1.
//   range_err<=1 when borrow occurs (data_in<prev_sum) or diff >= 2**word_size.
//     data_out still takes the truncated low bits. The state is not disturbed.
//   enable=0: data_out holds its last value. sample_valid, frame_start and range_err
//     drive 0. prev_sum and count are frozen; count is then overridden to 0 on resume.
//   Wrap: after count==3, the next consumed sample is frame sample 0. prev_sum is
//     ignored for that sample.
//   IDLE differs from HOLD only in data_out: 0 after reset vs the last value held.
//   Reset mid-frame: all outputs return to reset values on the next edge. The next
//     enabled sample is a frame start.
// STRUCTURE
//   Shared package: FSM state encoding (IDLE/RUN/HOLD), FRAME_LEN=4, count width 2.
//   Sub-module differentiator_controller: FSM and count. It outputs load_first,
//     load_diff and hold to the datapath held in this top module.
//   Datapath: prev_sum register, subtractor with borrow, range check, output regs.
// TESTING (word_size=3)
//   1 Sums 3,8,10,17 with enable held 1 -> data_out 3,5,2,7. frame_start on 3 only.
//     range_err=0 throughout.
//   2 Sums 3,8,10,17,1,4 -> sixth edge gives data_out 1 with frame_start=1 (wrap),
//     then 3.
//   3 Sums 3,8; enable=0 for 3 cycles -> data_out holds 5, sample_valid=0.
//     Resume with 4 -> data_out 4, frame_start=1.
//   4 Sums 10 then 6 -> range_err=1 (borrow), data_out=(6-10) mod 8 = 4.
//     Sums 0 then 9 -> range_err=1 (diff 9 >= 8), data_out=1.
//   5 Sums 3,8, reset asserted together with enable and data_in=10 -> all outputs 0.
//     Next enabled sum 6 -> data_out 6, frame_start=1.
//   6 First-of-frame sum 12 -> range_err=1, data_out=4.

Source files
------------

// File: rtl/differentiator_datapath_controller_pkg.sv
// Shared definitions for the differentiator: FSM state encoding and frame geometry.
// Imported by the controller and the datapath top.
package differentiator_datapath_controller_pkg;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/differentiator_datapath_controller_if.sv
// Stream bundle between the partial-sum source and the differentiator.
// master drives enable/data_in; slave returns the recovered sample and flags.
interface differentiator_datapath_controller_if #(
  parameter int word_size = 3
);

  logic                 enable;
  logic [word_size+1:0] data_in;
  logic [word_size-1:0] data_out;
  logic                 sample_valid;
  logic                 frame_start;
  logic                 range_err;

  modport master (
    output enable,
    output data_in,
    input  data_out,
    input  sample_valid,
    input  frame_start,
    input  range_err
  );

  modport slave (
    input  enable,
    input  data_in,
    output data_out,
    output sample_valid,
    output frame_start,
    output range_err
  );

endinterface

// File: rtl/differentiator_datapath_controller_controller.sv
// Frame controller: tracks position within a 4-sample frame and run/hold state.
// Combinational load strobes from enable; no backpressure, enable=0 simply holds.
module differentiator_controller
  import differentiator_datapath_controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic load_first,
  output logic load_diff,
  output logic hold
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  cnt_t       count;
  cnt_t       cnt_eff;

  // Leaving HOLD (or IDLE) always restarts the frame, so only RUN trusts count.
  always_comb begin
    cnt_eff    = (state == ST_RUN) ? count : '0;
    load_first = enable && (cnt_eff == '0);
    load_diff  = enable && (cnt_eff != '0);
    hold       = !enable;
    state_nxt  = state;
    if (enable) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      state_nxt = ST_HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (enable) begin
        count <= cnt_eff + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/differentiator_datapath_controller.sv
// Recovers samples from a 4-sample running-sum stream; data_in to data_out is 1 cycle.
// enable=0 holds data_out and freezes state; the next enabled sample starts a frame.
module differentiator_datapath_controller
  import differentiator_datapath_controller_pkg::*;
#(
  parameter int word_size = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  differentiator_datapath_controller_if.slave   bus
);

  localparam int SUM_W = word_size + 2;

  logic             load_first;
  logic             load_diff;
  logic             hold;
  logic [SUM_W-1:0] prev_sum;
  logic [SUM_W:0]   diff_ext;
  logic [SUM_W-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             range_bad;

  differentiator_controller u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .enable     (bus.enable),
    .load_first (load_first),
    .load_diff  (load_diff),
    .hold       (hold)
  );

  // One extra bit on the subtraction exposes the borrow directly.
  always_comb begin
    diff_ext  = {1'b0, bus.data_in} - {1'b0, prev_sum};
    borrow    = diff_ext[SUM_W];
    diff      = load_first ? bus.data_in : diff_ext[SUM_W-1:0];
    overflow  = |diff[SUM_W-1:word_size];
    range_bad = overflow || (load_diff && borrow);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_sum         <= '0;
      bus.data_out     <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.range_err    <= 1'b0;
    end else if (load_first || load_diff) begin
      prev_sum         <= bus.data_in;
      bus.data_out     <= diff[word_size-1:0];
      bus.sample_valid <= 1'b1;
      bus.frame_start  <= load_first;
      bus.range_err    <= range_bad;
    end else if (hold) begin
      bus.sample_valid <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.range_err    <= 1'b0;
    end
  end

endmodule
